// File: rtl/vga_fb_write_arbiter.sv
// Frame-buffer write scheduler: round-robin between bus pixel writes and a rectangle-fill engine.
// Optional macro VGA_FB_VBLANK_SYNC_EN holds a fill in ARM until a rising vblank edge.
module vga_fb_write_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_WIDTH  = 48,
    parameter int IMG_HEIGHT = 48,
    localparam int IDX_W = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int CW    = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT)
) (
    input  logic                  ahb_clk,
    input  logic                  n_rst,
    input  logic                  bus_req,
    input  logic [IDX_W-1:0]      bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_gnt,
    input  logic                  fill_start,
    input  logic [CW-1:0]         fill_x0,
    input  logic [CW-1:0]         fill_x1,
    input  logic [CW-1:0]         fill_y0,
    input  logic [CW-1:0]         fill_y1,
    input  logic [DATA_WIDTH-1:0] fill_color,
    input  logic                  vblank,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  fb_wen,
    output logic [IDX_W-1:0]      fb_waddr,
    output logic [DATA_WIDTH-1:0] fb_wdata
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [CW-1:0] X_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(IMG_HEIGHT - 1);
    localparam logic RR_BUS  = 1'b0;
    localparam logic RR_FILL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic [CW-1:0]         x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]         x_q, x_d, y_q, y_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  fill_busy_q, fill_busy_d;
    logic                  fill_done_q, fill_done_d;
    logic                  fb_wen_q, fb_wen_d;
    logic [IDX_W-1:0]      fb_waddr_q, fb_waddr_d;
    logic [DATA_WIDTH-1:0] fb_wdata_q, fb_wdata_d;

    logic                  fill_req_s, fill_gnt_s, bus_gnt_s, bus_in_range_s;
    logic [CW-1:0]         x1_clamp_s, y1_clamp_s;
    logic                  degenerate_s;
    logic [IDX_W-1:0]      fill_addr_s;

`ifdef VGA_FB_VBLANK_SYNC_EN
    logic vblank_q;
`else
    logic unused_vblank_s;
    assign unused_vblank_s = vblank;
`endif

    // Arbitration and write-port datapath
    always_comb begin
        fill_req_s     = (state_q == S_FILL);
        bus_gnt_s      = n_rst && bus_req && (!fill_req_s || (rr_last_q == RR_FILL));
        fill_gnt_s     = fill_req_s && !bus_gnt_s;
        bus_in_range_s = ({1'b0, bus_addr} < (IDX_W + 1)'(NPIX));
        fill_addr_s    = IDX_W'(y_q) * IDX_W'(IMG_WIDTH) + IDX_W'(x_q);
        fb_wen_d       = 1'b0;
        fb_waddr_d     = fb_waddr_q;
        fb_wdata_d     = fb_wdata_q;
        rr_last_d      = rr_last_q;
        if (bus_gnt_s) begin
            rr_last_d = RR_BUS;
            if (bus_in_range_s) begin
                fb_wen_d   = 1'b1;
                fb_waddr_d = bus_addr;
                fb_wdata_d = bus_wdata;
            end else begin
                fb_wen_d = 1'b0;
            end
        end else if (fill_gnt_s) begin
            rr_last_d  = RR_FILL;
            fb_wen_d   = 1'b1;
            fb_waddr_d = fill_addr_s;
            fb_wdata_d = color_q;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Fill engine sequencing and raster counters
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        x1_clamp_s   = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
        y1_clamp_s   = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
        degenerate_s = (fill_x0 > x1_clamp_s) || (fill_y0 > y1_clamp_s);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (fill_start) begin
                    x0_d    = fill_x0;
                    x1_d    = x1_clamp_s;
                    y1_d    = y1_clamp_s;
                    x_d     = fill_x0;
                    y_d     = fill_y0;
                    color_d = fill_color;
                    state_d = degenerate_s ? S_DONE : S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
`ifdef VGA_FB_VBLANK_SYNC_EN
                if (vblank && !vblank_q) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_ARM;
                end
`else
                state_d = S_FILL;
`endif
            end
            S_FILL: begin
                if (fill_gnt_s) begin
                    if (x_q == x1_q) begin
                        x_d = x0_q;
                        if (y_q == y1_q) begin
                            state_d = S_DONE;
                        end else begin
                            y_d = y_q + CW'(1);
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
        fill_busy_d = (state_d == S_ARM) || (state_d == S_FILL);
        fill_done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ahb_clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            rr_last_q   <= RR_FILL;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            fb_wen_q    <= 1'b0;
            fb_waddr_q  <= '0;
            fb_wdata_q  <= '0;
`ifdef VGA_FB_VBLANK_SYNC_EN
            vblank_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            fill_busy_q <= fill_busy_d;
            fill_done_q <= fill_done_d;
            fb_wen_q    <= fb_wen_d;
            fb_waddr_q  <= fb_waddr_d;
            fb_wdata_q  <= fb_wdata_d;
`ifdef VGA_FB_VBLANK_SYNC_EN
            vblank_q    <= vblank;
`endif
        end
    end

    assign bus_gnt   = bus_gnt_s;
    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;
    assign fb_wen    = fb_wen_q;
    assign fb_waddr  = fb_waddr_q;
    assign fb_wdata  = fb_wdata_q;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed self-checking bench for vga_fb_write_arbiter (48x48, 24-bit pixels).
module tb_vga_fb_write_arbiter;

    logic        ahb_clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        bus_req = 1'b0;
    logic [11:0] bus_addr = 12'd0;
    logic [23:0] bus_wdata = 24'd0;
    logic        bus_gnt;
    logic        fill_start = 1'b0;
    logic [5:0]  fill_x0 = 6'd0, fill_x1 = 6'd0, fill_y0 = 6'd0, fill_y1 = 6'd0;
    logic [23:0] fill_color = 24'd0;
    logic        vblank = 1'b0;
    logic        fill_busy, fill_done, fb_wen;
    logic [11:0] fb_waddr;
    logic [23:0] fb_wdata;

    int total = 0;
    int bad = 0;

    vga_fb_write_arbiter dut (
        .ahb_clk(ahb_clk), .n_rst(n_rst),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
        .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color),
        .vblank(vblank), .fill_busy(fill_busy), .fill_done(fill_done),
        .fb_wen(fb_wen), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata)
    );

    always #5 ahb_clk = ~ahb_clk;

    task automatic tick();
        @(posedge ahb_clk);
        #1;
    endtask

    // Pulse fill_start for one cycle; returns in the cycle after the start.
    task automatic start_fill(input logic [5:0] x0, input logic [5:0] x1,
                              input logic [5:0] y0, input logic [5:0] y1, input logic [23:0] c);
        fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; bus_req = 1'b1; bus_addr = 12'd9; bus_wdata = 24'hFFFFFF;
        fill_start = 1'b1; fill_x0 = 6'd0; fill_x1 = 6'd3; fill_y0 = 6'd0; fill_y1 = 6'd0;
        fill_color = 24'hFFFFFF; vblank = 1'b1;
        #1;
        total++;
        if (bus_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_early: got %b want 0", bus_gnt); end
        tick(); tick();
        total++;
        if ({bus_gnt, fill_busy, fill_done, fb_wen, fb_waddr, fb_wdata} !== {4'b0000, 12'd0, 24'd0}) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b wen=%b addr=%0d data=%h want all 0",
                     bus_gnt, fill_busy, fill_done, fb_wen, fb_waddr, fb_wdata);
        end
        bus_req = 1'b0; fill_start = 1'b0; vblank = 1'b0; n_rst = 1'b1;
        tick();
        total++;
        if ({bus_gnt, fill_busy, fill_done, fb_wen} !== 4'b0000) begin
            bad++; $display("FAIL reset_idle: got %b want 0000", {bus_gnt, fill_busy, fill_done, fb_wen});
        end
    endtask

    task automatic test_bus_write();
        bus_req = 1'b1; bus_addr = 12'd5; bus_wdata = 24'hFF0000;
        #1;
        total++;
        if (bus_gnt !== 1'b1) begin bad++; $display("FAIL bus_gnt: got %b want 1", bus_gnt); end
        tick();
        bus_req = 1'b0;
        total++;
        if ({fb_wen, fb_waddr, fb_wdata} !== {1'b1, 12'd5, 24'hFF0000}) begin
            bad++; $display("FAIL bus_write: got wen=%b addr=%0d data=%h want 1/5/ff0000", fb_wen, fb_waddr, fb_wdata);
        end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata} !== {1'b0, 12'd5, 24'hFF0000}) begin
            bad++; $display("FAIL bus_hold: got wen=%b addr=%0d data=%h want 0/5/ff0000", fb_wen, fb_waddr, fb_wdata);
        end
    endtask

    task automatic test_full_fill();
        start_fill(6'd0, 6'd47, 6'd0, 6'd47, 24'h00FF00);
        total++;
        if ({fill_busy, fill_done, fb_wen} !== 3'b100) begin
            bad++; $display("FAIL full_arm: got busy/done/wen=%b want 100", {fill_busy, fill_done, fb_wen});
        end
        tick();
        total++;
        if ({fill_busy, fb_wen} !== 2'b10) begin
            bad++; $display("FAIL full_first: got busy/wen=%b want 10", {fill_busy, fb_wen});
        end
        for (int i = 0; i < 2304; i++) begin
            tick();
            total++;
            if ({fb_wen, fb_waddr, fb_wdata, fill_busy, fill_done} !==
                {1'b1, 12'(i), 24'h00FF00, ((i == 2303) ? 2'b01 : 2'b10)}) begin
                bad++;
                $display("FAIL full_px%0d: got wen=%b addr=%0d data=%h busy=%b done=%b want addr=%0d",
                         i, fb_wen, fb_waddr, fb_wdata, fill_busy, fill_done, i);
            end
        end
        tick();
        total++;
        if ({fb_wen, fill_busy, fill_done} !== 3'b000) begin
            bad++; $display("FAIL full_after: got wen/busy/done=%b want 000", {fb_wen, fill_busy, fill_done});
        end
    endtask

    task automatic test_arbitration();
        start_fill(6'd1, 6'd2, 6'd1, 6'd1, 24'hABCDEF);
        bus_req = 1'b1; bus_addr = 12'd7; bus_wdata = 24'h123456;
        #1;
        total++;
        if (bus_gnt !== 1'b1) begin bad++; $display("FAIL arb_gnt_arm: got %b want 1", bus_gnt); end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, bus_gnt} !== {1'b1, 12'd7, 24'h123456, 1'b0}) begin
            bad++; $display("FAIL arb_w1: got wen=%b addr=%0d data=%h gnt=%b want 1/7/123456 gnt 0", fb_wen, fb_waddr, fb_wdata, bus_gnt);
        end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, bus_gnt} !== {1'b1, 12'd49, 24'hABCDEF, 1'b1}) begin
            bad++; $display("FAIL arb_w2: got wen=%b addr=%0d data=%h gnt=%b want 1/49/abcdef gnt 1", fb_wen, fb_waddr, fb_wdata, bus_gnt);
        end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, bus_gnt, fill_done} !== {1'b1, 12'd7, 24'h123456, 2'b00}) begin
            bad++; $display("FAIL arb_w3: got wen=%b addr=%0d data=%h gnt=%b done=%b want 1/7/123456 0 0", fb_wen, fb_waddr, fb_wdata, bus_gnt, fill_done);
        end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, fill_done, fill_busy, bus_gnt} !== {1'b1, 12'd50, 24'hABCDEF, 3'b101}) begin
            bad++; $display("FAIL arb_w4: got wen=%b addr=%0d data=%h done=%b busy=%b gnt=%b want 1/50/abcdef 1 0 1", fb_wen, fb_waddr, fb_wdata, fill_done, fill_busy, bus_gnt);
        end
        tick();
        bus_req = 1'b0;
        total++;
        if ({fb_wen, fb_waddr, fill_done} !== {1'b1, 12'd7, 1'b0}) begin
            bad++; $display("FAIL arb_w5: got wen=%b addr=%0d done=%b want 1/7/0", fb_wen, fb_waddr, fill_done);
        end
    endtask

    task automatic test_boundaries();
        start_fill(6'd5, 6'd3, 6'd0, 6'd0, 24'h777777);
        total++;
        if ({fill_busy, fill_done, fb_wen} !== 3'b010) begin
            bad++; $display("FAIL degen_done: got busy/done/wen=%b want 010", {fill_busy, fill_done, fb_wen});
        end
        tick();
        total++;
        if ({fill_busy, fill_done, fb_wen} !== 3'b000) begin
            bad++; $display("FAIL degen_after: got busy/done/wen=%b want 000", {fill_busy, fill_done, fb_wen});
        end
        bus_req = 1'b1; bus_addr = 12'd2304; bus_wdata = 24'hEEEEEE;
        #1;
        total++;
        if (bus_gnt !== 1'b1) begin bad++; $display("FAIL oor_gnt: got %b want 1", bus_gnt); end
        tick();
        bus_req = 1'b0;
        total++;
        if ({fb_wen, fb_waddr, fb_wdata} !== {1'b0, 12'd7, 24'h123456}) begin
            bad++; $display("FAIL oor_drop: got wen=%b addr=%0d data=%h want 0/7/123456", fb_wen, fb_waddr, fb_wdata);
        end
        start_fill(6'd46, 6'd60, 6'd0, 6'd0, 24'h0000AA);
        tick();
        total++;
        if ({fill_busy, fb_wen} !== 2'b10) begin
            bad++; $display("FAIL clamp_wait: got busy/wen=%b want 10", {fill_busy, fb_wen});
        end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, fill_done} !== {1'b1, 12'd46, 24'h0000AA, 1'b0}) begin
            bad++; $display("FAIL clamp_w46: got wen=%b addr=%0d data=%h done=%b want 1/46/0000aa/0", fb_wen, fb_waddr, fb_wdata, fill_done);
        end
        tick();
        total++;
        if ({fb_wen, fb_waddr, fill_done, fill_busy} !== {1'b1, 12'd47, 2'b10}) begin
            bad++; $display("FAIL clamp_w47: got wen=%b addr=%0d done=%b busy=%b want 1/47/1/0", fb_wen, fb_waddr, fill_done, fill_busy);
        end
        // start a new fill in the DONE cycle
        start_fill(6'd0, 6'd0, 6'd2, 6'd2, 24'h000055);
        total++;
        if ({fill_busy, fill_done, fb_wen} !== 3'b100) begin
            bad++; $display("FAIL b2b_arm: got busy/done/wen=%b want 100", {fill_busy, fill_done, fb_wen});
        end
        tick();
        tick();
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, fill_done} !== {1'b1, 12'd96, 24'h000055, 1'b1}) begin
            bad++; $display("FAIL b2b_w96: got wen=%b addr=%0d data=%h done=%b want 1/96/000055/1", fb_wen, fb_waddr, fb_wdata, fill_done);
        end
    endtask

    task automatic test_reset_mid_fill();
        int seen;
        start_fill(6'd0, 6'd47, 6'd0, 6'd47, 24'h111111);
        tick(); tick(); tick();
        n_rst = 1'b0; bus_req = 1'b1; bus_addr = 12'd3;
        #1;
        total++;
        if (bus_gnt !== 1'b0) begin bad++; $display("FAIL midrst_gnt: got %b want 0", bus_gnt); end
        tick();
        bus_req = 1'b0;
        total++;
        if ({fill_busy, fill_done, fb_wen, fb_waddr, fb_wdata} !== {3'b000, 12'd0, 24'd0}) begin
            bad++; $display("FAIL midrst_out: got busy=%b done=%b wen=%b addr=%0d data=%h want 0", fill_busy, fill_done, fb_wen, fb_waddr, fb_wdata);
        end
        n_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fill_done || fill_busy || fb_wen) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midrst_abort: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_vblank();
        int seen;
        vblank = 1'b0;
        start_fill(6'd3, 6'd3, 6'd0, 6'd0, 24'h0F0F0F);
`ifdef VGA_FB_VBLANK_SYNC_EN
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!fill_busy || fb_wen) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL vb_hold: got %0d bad cycles want 0", seen); end
        vblank = 1'b1;
        tick();
        total++;
        if ({fill_busy, fb_wen} !== 2'b10) begin
            bad++; $display("FAIL vb_fill: got busy/wen=%b want 10", {fill_busy, fb_wen});
        end
        tick();
        vblank = 1'b0;
`else
        seen = 0;
        total++;
        if ({fill_busy, fb_wen} !== 2'b10) begin
            bad++; $display("FAIL nvb_arm: got busy/wen=%b want 10", {fill_busy, fb_wen});
        end
        tick();
        total++;
        if ({fill_busy, fb_wen} !== 2'b10) begin
            bad++; $display("FAIL nvb_fill: got busy/wen=%b want 10", {fill_busy, fb_wen});
        end
        tick();
`endif
        total++;
        if ({fb_wen, fb_waddr, fb_wdata, fill_done, seen[0]} !== {1'b1, 12'd3, 24'h0F0F0F, 2'b10}) begin
            bad++; $display("FAIL vb_write: got wen=%b addr=%0d data=%h done=%b want 1/3/0f0f0f/1", fb_wen, fb_waddr, fb_wdata, fill_done);
        end
    endtask

    initial begin
        test_reset();
        test_bus_write();
        test_full_fill();
        test_arbitration();
        test_boundaries();
        test_reset_mid_fill();
        test_vblank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
